// File: rtl/digit_entry_ctrl_if.sv
// Keypad-to-setpoint bundle: debounced button levels in, edited/committed BCD setpoint and LCD strobe out.
// The master side is the button/panel side; the slave side is the entry controller.
interface digit_entry_ctrl_if #(
  parameter int N_DIGITS = 3
);
  localparam int NUM_W = $clog2(N_DIGITS);

  logic                  Left;
  logic                  Right;
  logic                  Up;
  logic                  Down;
  logic                  Enter;
  logic [4*N_DIGITS-1:0] EditValue;
  logic [4*N_DIGITS-1:0] CommitValue;
  logic                  CommitValid;
  logic                  RangeErr;
  logic [NUM_W-1:0]      Num;
  logic                  LCD_Enable;
  logic [3:0]            LCD_Num;

  modport master (
    output Left, Right, Up, Down, Enter,
    input  EditValue, CommitValue, CommitValid, RangeErr, Num, LCD_Enable, LCD_Num
  );

  modport slave (
    input  Left, Right, Up, Down, Enter,
    output EditValue, CommitValue, CommitValid, RangeErr, Num, LCD_Enable, LCD_Num
  );
endinterface

// File: rtl/digit_entry_ctrl.sv
// N-digit BCD setpoint editor: cursor movement, wrap-around digit stepping with auto-repeat,
// range-clamped commit and a one-cycle LCD redraw strobe whenever the cursor or a digit changes.
module digit_entry_ctrl #(
  parameter int N_DIGITS     = 3,
  parameter int MIN_VAL      = 0,
  parameter int MAX_VAL      = 999,
  parameter int REPEAT_DELAY = 50,
  parameter int REPEAT_RATE  = 10
) (
  input  logic              sysclk,
  input  logic              INIT_n,
  digit_entry_ctrl_if.slave bus
);
  localparam int NUM_W   = $clog2(N_DIGITS);
  localparam int D_W     = 4 * N_DIGITS;
  localparam int VAL_W   = $clog2(10 ** N_DIGITS);
  localparam int CNT_MAX = (REPEAT_DELAY > REPEAT_RATE) ? REPEAT_DELAY : REPEAT_RATE;
  localparam int CNT_W   = $clog2(CNT_MAX + 1);

  localparam logic [1:0] S_IDLE   = 2'd0;
  localparam logic [1:0] S_HOLD   = 2'd1;
  localparam logic [1:0] S_REPEAT = 2'd2;
  localparam logic [1:0] S_COMMIT = 2'd3;

  localparam int B_DOWN  = 0;
  localparam int B_UP    = 1;
  localparam int B_RIGHT = 2;
  localparam int B_LEFT  = 3;
  localparam int B_ENTER = 4;

  localparam logic [NUM_W-1:0] NUM_LAST = NUM_W'(N_DIGITS - 1);

  function automatic logic [D_W-1:0] to_bcd(input int value);
    logic [D_W-1:0] r;
    int             v;
    r = '0;
    v = value;
    for (int i = 0; i < N_DIGITS; i++) begin
      r[4*i +: 4] = 4'(v % 10);
      v = v / 10;
    end
    return r;
  endfunction

  localparam logic [D_W-1:0] MIN_BCD = to_bcd(MIN_VAL);
  localparam logic [D_W-1:0] MAX_BCD = to_bcd(MAX_VAL);

  logic [1:0]       state_reg, state_next;
  logic [NUM_W-1:0] num_reg, num_next;
  logic [D_W-1:0]   edit_reg, edit_next;
  logic [D_W-1:0]   commit_reg, commit_next;
  logic             valid_reg, valid_next;
  logic             err_reg, err_next;
  logic             lcd_en_reg, lcd_en_next;
  logic [CNT_W-1:0] cnt_reg, cnt_next;
  logic             dir_reg, dir_next;   // 1 = Up is the key being repeated
  logic [4:0]       prev_reg;

  logic [4:0]       btn;
  logic [4:0]       rise;
  logic [3:0]       digit [N_DIGITS];
  logic [VAL_W-1:0] partial [N_DIGITS+1];
  logic [VAL_W-1:0] edit_val;
  logic             over, under;
  logic [3:0]       cur_digit, inc_digit, dec_digit;
  logic [D_W-1:0]   edit_up, edit_down;
  logic [NUM_W-1:0] num_left, num_right;
  logic [CNT_W-1:0] cnt_inc, cnt_limit;
  logic             held_same, held_other, do_commit;

  assign btn  = {bus.Enter, bus.Left, bus.Right, bus.Up, bus.Down};
  assign rise = btn & ~prev_reg;

  // Weighted BCD-to-binary sum, one adder stage per digit.
  assign partial[0] = '0;
  for (genvar gi = 0; gi < N_DIGITS; gi++) begin : g_digit
    assign digit[gi]         = edit_reg[4*gi +: 4];
    assign partial[gi+1]     = partial[gi] + VAL_W'(digit[gi]) * VAL_W'(10 ** gi);
    assign edit_up[4*gi +: 4]   = (num_reg == NUM_W'(gi)) ? inc_digit : digit[gi];
    assign edit_down[4*gi +: 4] = (num_reg == NUM_W'(gi)) ? dec_digit : digit[gi];
  end
  assign edit_val = partial[N_DIGITS];

  assign over = edit_val > VAL_W'(MAX_VAL);
  if (MIN_VAL == 0) begin : g_no_min
    assign under = 1'b0;
  end else begin : g_min
    assign under = edit_val < VAL_W'(MIN_VAL);
  end

  assign cur_digit = digit[num_reg];
  assign inc_digit = (cur_digit == 4'd9) ? 4'd0 : cur_digit + 4'd1;
  assign dec_digit = (cur_digit == 4'd0) ? 4'd9 : cur_digit - 4'd1;
  assign num_left  = (num_reg == NUM_LAST) ? '0 : num_reg + 1'b1;
  assign num_right = (num_reg == '0) ? NUM_LAST : num_reg - 1'b1;

  assign cnt_inc    = cnt_reg + 1'b1;
  assign cnt_limit  = (state_reg == S_HOLD) ? CNT_W'(REPEAT_DELAY) : CNT_W'(REPEAT_RATE);
  assign held_same  = dir_reg ? btn[B_UP] : btn[B_DOWN];
  assign held_other = dir_reg ? btn[B_DOWN] : btn[B_UP];

  always_comb begin
    state_next  = state_reg;
    num_next    = num_reg;
    edit_next   = edit_reg;
    commit_next = commit_reg;
    cnt_next    = cnt_reg;
    dir_next    = dir_reg;
    valid_next  = 1'b0;
    err_next    = 1'b0;
    do_commit   = 1'b0;

    case (state_reg)
      S_IDLE: begin
        if (rise[B_ENTER]) begin
          do_commit = 1'b1;
        end else if (rise[B_LEFT] || rise[B_RIGHT]) begin
          // A cursor edge consumes the cycle even when Left and Right cancel out.
          if (rise[B_LEFT] && !btn[B_RIGHT]) begin
            num_next = num_left;
          end else if (rise[B_RIGHT] && !btn[B_LEFT]) begin
            num_next = num_right;
          end
        end else if (rise[B_UP] && !btn[B_DOWN]) begin
          edit_next  = edit_up;
          dir_next   = 1'b1;
          cnt_next   = '0;
          state_next = S_HOLD;
        end else if (rise[B_DOWN] && !btn[B_UP]) begin
          edit_next  = edit_down;
          dir_next   = 1'b0;
          cnt_next   = '0;
          state_next = S_HOLD;
        end
      end
      S_HOLD, S_REPEAT: begin
        if (rise[B_ENTER]) begin
          do_commit = 1'b1;
        end else if (held_other || !held_same) begin
          state_next = S_IDLE;
          cnt_next   = '0;
        end else begin
          cnt_next = cnt_inc;
          if (cnt_inc == cnt_limit) begin
            edit_next  = dir_reg ? edit_up : edit_down;
            cnt_next   = '0;
            state_next = S_REPEAT;
          end
        end
      end
      default: begin
        state_next = S_IDLE;
      end
    endcase

    if (do_commit) begin
      state_next = S_COMMIT;
      cnt_next   = '0;
      valid_next = 1'b1;
      if (over) begin
        commit_next = MAX_BCD;
        edit_next   = MAX_BCD;
        err_next    = 1'b1;
      end else if (under) begin
        commit_next = MIN_BCD;
        edit_next   = MIN_BCD;
        err_next    = 1'b1;
      end else begin
        commit_next = edit_reg;
      end
    end
  end

  assign lcd_en_next = (edit_next != edit_reg) || (num_next != num_reg);

  always_ff @(posedge sysclk or negedge INIT_n) begin
    if (!INIT_n) begin
      state_reg  <= S_IDLE;
      num_reg    <= '0;
      edit_reg   <= '0;
      commit_reg <= '0;
      valid_reg  <= 1'b0;
      err_reg    <= 1'b0;
      lcd_en_reg <= 1'b0;
      cnt_reg    <= '0;
      dir_reg    <= 1'b0;
      prev_reg   <= '1;   // a button already held at reset release is not an edge
    end else begin
      state_reg  <= state_next;
      num_reg    <= num_next;
      edit_reg   <= edit_next;
      commit_reg <= commit_next;
      valid_reg  <= valid_next;
      err_reg    <= err_next;
      lcd_en_reg <= lcd_en_next;
      cnt_reg    <= cnt_next;
      dir_reg    <= dir_next;
      prev_reg   <= btn;
    end
  end

  assign bus.EditValue   = edit_reg;
  assign bus.CommitValue = commit_reg;
  assign bus.CommitValid = valid_reg;
  assign bus.RangeErr    = err_reg;
  assign bus.Num         = num_reg;
  assign bus.LCD_Enable  = lcd_en_reg;
  assign bus.LCD_Num     = digit[num_reg];
endmodule

// File: tb/tb_digit_entry_ctrl.sv
// Directed bench for digit_entry_ctrl: two instances share the buttons, one full-range and one
// clamped to 100..500; commits are predicted into per-instance queues and checked when CommitValid fires.
module tb_digit_entry_ctrl;
  localparam int K_LEFT  = 0;
  localparam int K_RIGHT = 1;
  localparam int K_UP    = 2;
  localparam int K_DOWN  = 3;
  localparam int K_ENTER = 4;

  typedef struct packed {
    logic [11:0] commit;
    logic        err;
    logic [11:0] edit;
  } exp_t;

  logic clk;
  logic init_n;
  logic left, right, up, down, enter;
  int   tests;
  int   failed;
  exp_t q_a[$];
  exp_t q_b[$];
  exp_t ea, eb;

  digit_entry_ctrl_if #(.N_DIGITS(3)) ifa ();
  digit_entry_ctrl_if #(.N_DIGITS(3)) ifb ();

  assign ifa.Left = left;   assign ifb.Left = left;
  assign ifa.Right = right; assign ifb.Right = right;
  assign ifa.Up = up;       assign ifb.Up = up;
  assign ifa.Down = down;   assign ifb.Down = down;
  assign ifa.Enter = enter; assign ifb.Enter = enter;

  digit_entry_ctrl #(
    .N_DIGITS(3), .MIN_VAL(0), .MAX_VAL(999), .REPEAT_DELAY(50), .REPEAT_RATE(10)
  ) dut_a (
    .sysclk(clk), .INIT_n(init_n), .bus(ifa.slave)
  );

  digit_entry_ctrl #(
    .N_DIGITS(3), .MIN_VAL(100), .MAX_VAL(500), .REPEAT_DELAY(50), .REPEAT_RATE(10)
  ) dut_b (
    .sysclk(clk), .INIT_n(init_n), .bus(ifb.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      failed++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick(input int n = 1);
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic set_key(input int k, input logic v);
    case (k)
      K_LEFT:  left  = v;
      K_RIGHT: right = v;
      K_UP:    up    = v;
      K_DOWN:  down  = v;
      default: enter = v;
    endcase
  endtask

  task automatic press(input int k);
    set_key(k, 1'b1);
    tick();
    set_key(k, 1'b0);
    tick();
  endtask

  task automatic push_commit(input logic [11:0] ca, input logic era,
                             input logic [11:0] cb, input logic erb);
    q_a.push_back('{commit: ca, err: era, edit: ca});
    q_b.push_back('{commit: cb, err: erb, edit: cb});
  endtask

  // Scoreboard side: every CommitValid pulse must match the oldest predicted commit.
  always @(negedge clk) begin
    if (ifa.CommitValid) begin
      if (q_a.size() == 0) begin
        chk("a_unexpected_commit", 32'(ifa.CommitValid), 32'd0);
      end else begin
        ea = q_a.pop_front();
        $display("[TB] commit A value=%h err=%0d", ifa.CommitValue, ifa.RangeErr);
        chk("a_commit_value", 32'(ifa.CommitValue), 32'(ea.commit));
        chk("a_range_err", 32'(ifa.RangeErr), 32'(ea.err));
        chk("a_commit_edit", 32'(ifa.EditValue), 32'(ea.edit));
      end
    end
    if (ifb.CommitValid) begin
      if (q_b.size() == 0) begin
        chk("b_unexpected_commit", 32'(ifb.CommitValid), 32'd0);
      end else begin
        eb = q_b.pop_front();
        $display("[TB] commit B value=%h err=%0d", ifb.CommitValue, ifb.RangeErr);
        chk("b_commit_value", 32'(ifb.CommitValue), 32'(eb.commit));
        chk("b_range_err", 32'(ifb.RangeErr), 32'(eb.err));
        chk("b_commit_edit", 32'(ifb.EditValue), 32'(eb.edit));
      end
    end
  end

  initial begin
    tests  = 0;
    failed = 0;
    init_n = 1'b0;
    left = 1'b0; right = 1'b0; up = 1'b1; down = 1'b0; enter = 1'b0;

    // Reset with Up held, then release it still held: no step may result.
    tick(2);
    chk("rst_edit", 32'(ifa.EditValue), 32'h000);
    chk("rst_commit", 32'(ifa.CommitValue), 32'h000);
    chk("rst_num", 32'(ifa.Num), 32'd0);
    chk("rst_valid", 32'(ifa.CommitValid), 32'd0);
    init_n = 1'b1;
    for (int i = 0; i < 5; i++) begin
      tick();
      chk("held_up_lcd", 32'(ifa.LCD_Enable), 32'd0);
    end
    chk("held_up_edit", 32'(ifa.EditValue), 32'h000);
    chk("held_up_num", 32'(ifa.Num), 32'd0);
    up = 1'b0;
    tick();

    // Down twice on each digit, moving Left in between, then commit.
    press(K_DOWN); press(K_DOWN);
    chk("d0_edit", 32'(ifa.EditValue), 32'h008);
    press(K_LEFT);
    chk("left_num1", 32'(ifa.Num), 32'd1);
    press(K_DOWN); press(K_DOWN);
    press(K_LEFT);
    press(K_DOWN); press(K_DOWN);
    chk("pre_commit_edit", 32'(ifa.EditValue), 32'h888);
    chk("pre_commit_num", 32'(ifa.Num), 32'd2);
    push_commit(12'h888, 1'b0, 12'h500, 1'b1);
    enter = 1'b1;
    tick();
    chk("a_commit_valid", 32'(ifa.CommitValid), 32'd1);
    chk("a_noclamp_lcd", 32'(ifa.LCD_Enable), 32'd0);
    chk("b_clamp_lcd", 32'(ifb.LCD_Enable), 32'd1);
    chk("b_clamp_lcd_num", 32'(ifb.LCD_Num), 32'd5);
    tick(4);   // Enter still held: no further commits
    chk("a_valid_one_cycle", 32'(ifa.CommitValid), 32'd0);
    enter = 1'b0;
    tick();
    chk("a_commit_hold", 32'(ifa.CommitValue), 32'h888);
    chk("b_edit_clamped", 32'(ifb.EditValue), 32'h500);

    // Cursor wrap both ways, digit wrap without carry/borrow.
    press(K_LEFT);
    chk("wrap_left_num", 32'(ifa.Num), 32'd0);
    press(K_RIGHT);
    chk("wrap_right_num", 32'(ifa.Num), 32'd2);
    press(K_LEFT);
    press(K_UP); press(K_UP);
    chk("up_wrap_edit", 32'(ifa.EditValue), 32'h880);
    chk("b_up_edit", 32'(ifb.EditValue), 32'h502);
    down = 1'b1;
    tick();
    chk("down_wrap_lcd_en", 32'(ifa.LCD_Enable), 32'd1);
    chk("down_wrap_lcd_num", 32'(ifa.LCD_Num), 32'd9);
    down = 1'b0;
    tick();
    chk("down_wrap_lcd_off", 32'(ifa.LCD_Enable), 32'd0);
    chk("down_wrap_edit", 32'(ifa.EditValue), 32'h889);

    // Auto-repeat: first step, one after the hold delay, then every repeat period.
    up = 1'b1;
    tick(50);
    chk("rep_before_delay", 32'(ifa.EditValue), 32'h880);
    tick();
    chk("rep_after_delay", 32'(ifa.EditValue), 32'h881);
    tick(34);
    chk("rep_final_a", 32'(ifa.EditValue), 32'h884);
    up = 1'b0;
    tick(20);
    chk("rep_released_a", 32'(ifa.EditValue), 32'h884);
    chk("rep_released_b", 32'(ifb.EditValue), 32'h506);

    // Over-range, under-range and in-range commits on the clamped instance.
    push_commit(12'h884, 1'b0, 12'h500, 1'b1);
    press(K_ENTER);
    press(K_LEFT); press(K_LEFT);
    for (int i = 0; i < 5; i++) press(K_DOWN);
    chk("under_pre_a", 32'(ifa.EditValue), 32'h384);
    chk("under_pre_b", 32'(ifb.EditValue), 32'h000);
    push_commit(12'h384, 1'b0, 12'h100, 1'b1);
    press(K_ENTER);
    chk("b_under_edit", 32'(ifb.EditValue), 32'h100);
    push_commit(12'h384, 1'b0, 12'h100, 1'b0);
    press(K_ENTER);

    // Asynchronous reset in the middle of auto-repeat.
    up = 1'b1;
    tick(60);
    init_n = 1'b0;
    #1;
    chk("async_edit", 32'(ifa.EditValue), 32'h000);
    chk("async_commit", 32'(ifa.CommitValue), 32'h000);
    chk("async_num", 32'(ifa.Num), 32'd0);
    chk("async_lcd", 32'(ifa.LCD_Enable), 32'd0);
    chk("async_b_edit", 32'(ifb.EditValue), 32'h000);
    tick(2);
    init_n = 1'b1;
    tick(10);
    chk("post_rst_edit", 32'(ifa.EditValue), 32'h000);
    chk("post_rst_lcd", 32'(ifa.LCD_Enable), 32'd0);
    up = 1'b0;
    tick(3);

    chk("a_commits_drained", 32'(q_a.size()), 32'd0);
    chk("b_commits_drained", 32'(q_b.size()), 32'd0);
    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end
endmodule
